// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I main controller: opcodes, state
// numbers and datapath select values.
package ctrl_pkg;

  localparam logic [6:0] OPCODE_LW     = 7'b0000011;
  localparam logic [6:0] OPCODE_SW     = 7'b0100011;
  localparam logic [6:0] OPCODE_RTP    = 7'b0110011;
  localparam logic [6:0] OPCODE_ITP    = 7'b0010011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_EXE_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_RD    = 4'd3;
  localparam logic [3:0] S_WB_MEM    = 4'd4;
  localparam logic [3:0] S_MEM_WR    = 4'd5;
  localparam logic [3:0] S_EXE_R     = 4'd6;
  localparam logic [3:0] S_WB_ALU    = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_EXE_I     = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_LUI       = 4'd11;
  localparam logic [3:0] S_JALR_ADDR = 4'd12;
  localparam logic [3:0] S_TRAP      = 4'd15;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RD1    = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RD2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_PASS_B = 2'b11;

  localparam logic [1:0] RES_ALU_OUT  = 2'b00;
  localparam logic [1:0] RES_MEM_DATA = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;

  // States that drive mem_req and therefore wait on mem_ready.
  function automatic logic is_access_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready and flags a timeout on the last
// allowed waiting cycle. MEM_TIMEOUT = 0 disables the timeout.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  localparam int CW    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LIMIT_V = LIMIT[CW-1:0];
  localparam logic TMO_EN = (MEM_TIMEOUT > 0);

  logic [CW-1:0] cnt_r;

  // Wait counter: idle outside access states, restarts on every completed access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (!waiting || mem_ready) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // A ready in the same cycle as the limit wins, so mem_ready masks the timeout.
  assign timeout = TMO_EN && waiting && !mem_ready && (cnt_r == LIMIT_V);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, with a memory wait timeout and a trap state.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT     = 0,
  parameter int SUPPORT_JALR    = 1,
  parameter int SUPPORT_AUIPC   = 1,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic [1:0] sel_alu_src_a,
  output logic [1:0] sel_alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] sel_result,
  output logic       sel_mem_addr,
  output logic       mem_req,
  output logic       we_mem,
  output logic       pc_update,
  output logic       we_ir,
  output logic       we_rf,
  output logic       branch,
  output logic       jalr_clr_lsb,
  output logic       illegal_instr,
  output logic       bus_err,
  output logic       instr_retired,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_ILLEGAL = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;

  logic [3:0] state_r, state_nxt_s;
  logic       illegal_r, bus_err_r;
  logic       waiting_s, timeout_s;

  assign waiting_s = is_access_state(state_r);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .waiting   (waiting_s),
    .mem_ready (mem_ready),
    .timeout   (timeout_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Trap cause flags, latched on the transition into S_TRAP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
    end else if (state_nxt_s == S_TRAP && state_r != S_TRAP) begin
      illegal_r <= (state_r == S_DECODE);
      bus_err_r <= waiting_s;
    end else begin
      illegal_r <= illegal_r;
      bus_err_r <= bus_err_r;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          state_nxt_s = (state_r == S_FETCH)  ? S_DECODE :
                        (state_r == S_MEM_RD) ? S_WB_MEM : S_FETCH;
        end else if (timeout_s) begin
          state_nxt_s = S_TRAP;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_DECODE: begin
        case (op)
          OPCODE_LW, OPCODE_SW: state_nxt_s = S_EXE_ADDR;
          OPCODE_RTP:           state_nxt_s = S_EXE_R;
          OPCODE_ITP:           state_nxt_s = S_EXE_I;
          OPCODE_BRANCH:        state_nxt_s = S_BRANCH;
          OPCODE_JAL:           state_nxt_s = S_JAL;
          OPCODE_LUI:           state_nxt_s = S_LUI;
          OPCODE_AUIPC:         state_nxt_s = (SUPPORT_AUIPC != 0) ? S_WB_ALU : S_ILLEGAL;
          OPCODE_JALR:          state_nxt_s = (SUPPORT_JALR != 0) ? S_JALR_ADDR : S_ILLEGAL;
          default:              state_nxt_s = S_ILLEGAL;
        endcase
      end
      S_EXE_ADDR:                 state_nxt_s = (op == OPCODE_LW) ? S_MEM_RD : S_MEM_WR;
      S_EXE_R, S_EXE_I, S_LUI:    state_nxt_s = S_WB_ALU;
      S_WB_MEM, S_WB_ALU, S_BRANCH: state_nxt_s = S_FETCH;
      S_JALR_ADDR:                state_nxt_s = S_JAL;
      S_JAL:                      state_nxt_s = S_WB_ALU;
      S_TRAP:                     state_nxt_s = S_TRAP;
      default:                    state_nxt_s = S_FETCH;
    endcase
  end

  // Datapath controls; anything not set in a state stays 0.
  always_comb begin
    sel_alu_src_a = SRC_A_PC;
    sel_alu_src_b = SRC_B_RD2;
    alu_op        = ALU_ADD;
    sel_result    = RES_ALU_OUT;
    sel_mem_addr  = 1'b0;
    mem_req       = 1'b0;
    we_mem        = 1'b0;
    pc_update     = 1'b0;
    we_ir         = 1'b0;
    we_rf         = 1'b0;
    branch        = 1'b0;
    jalr_clr_lsb  = 1'b0;
    instr_retired = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req       = 1'b1;
        sel_alu_src_b = SRC_B_FOUR;
        sel_result    = RES_ALU;
        we_ir         = mem_ready;
        pc_update     = mem_ready;
      end
      S_DECODE: begin
        sel_alu_src_a = SRC_A_OLD_PC;
        sel_alu_src_b = SRC_B_IMM;
      end
      S_EXE_ADDR, S_JALR_ADDR: begin
        sel_alu_src_a = SRC_A_RD1;
        sel_alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        mem_req      = 1'b1;
        sel_mem_addr = 1'b1;
      end
      S_WB_MEM: begin
        sel_result    = RES_MEM_DATA;
        we_rf         = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEM_WR: begin
        mem_req       = 1'b1;
        sel_mem_addr  = 1'b1;
        we_mem        = 1'b1;
        instr_retired = mem_ready;
      end
      S_EXE_R: begin
        sel_alu_src_a = SRC_A_RD1;
        alu_op        = ALU_FUNCT;
      end
      S_EXE_I: begin
        sel_alu_src_a = SRC_A_RD1;
        sel_alu_src_b = SRC_B_IMM;
        alu_op        = ALU_FUNCT;
      end
      S_LUI: begin
        sel_alu_src_a = SRC_A_ZERO;
        sel_alu_src_b = SRC_B_IMM;
        alu_op        = ALU_PASS_B;
      end
      S_WB_ALU: begin
        we_rf         = 1'b1;
        instr_retired = 1'b1;
      end
      S_BRANCH: begin
        sel_alu_src_a = SRC_A_RD1;
        alu_op        = ALU_SUB;
        branch        = 1'b1;
        instr_retired = 1'b1;
      end
      S_JAL: begin
        sel_alu_src_a = SRC_A_OLD_PC;
        sel_alu_src_b = SRC_B_FOUR;
        pc_update     = 1'b1;
        jalr_clr_lsb  = (op == OPCODE_JALR);
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign illegal_instr = (state_r == S_TRAP) && illegal_r;
  assign bus_err       = (state_r == S_TRAP) && bus_err_r;
  assign state_o       = state_r;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed-vector bench for multicycle_ctrl_fsm across three parameter sets:
// defaults, timeout 5 without JALR, and non-trapping illegal without AUIPC.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTP   = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b0000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic [6:0] op  [3];
  logic       rdy [3];
  logic [3:0] st  [3];
  logic [1:0] sa [3], sb [3], aop [3], sr [3];
  logic sma [3], mreq [3], wem [3], pcu [3], wir [3], wrf [3];
  logic br [3], jcl [3], ill [3], berr [3], ret [3];

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_ctrl_fsm #(
      .MEM_TIMEOUT     ((g == 1) ? 5 : 0),
      .SUPPORT_JALR    ((g == 1) ? 0 : 1),
      .SUPPORT_AUIPC   ((g == 2) ? 0 : 1),
      .TRAP_ON_ILLEGAL ((g == 2) ? 0 : 1)
    ) u_dut (
      .clk           (clk),
      .rst           (rst[g]),
      .op            (op[g]),
      .mem_ready     (rdy[g]),
      .sel_alu_src_a (sa[g]),
      .sel_alu_src_b (sb[g]),
      .alu_op        (aop[g]),
      .sel_result    (sr[g]),
      .sel_mem_addr  (sma[g]),
      .mem_req       (mreq[g]),
      .we_mem        (wem[g]),
      .pc_update     (pcu[g]),
      .we_ir         (wir[g]),
      .we_rf         (wrf[g]),
      .branch        (br[g]),
      .jalr_clr_lsb  (jcl[g]),
      .illegal_instr (ill[g]),
      .bus_err       (berr[g]),
      .instr_retired (ret[g]),
      .state_o       (st[g])
    );
  end

  task automatic vcheck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [6:0] o, input logic r);
    op[i]  = o;
    rdy[i] = r;
    #1;
  endtask

  // SW on instance 1 with memory never ready: 5 write cycles, then bus-error trap.
  task automatic sw_timeout(input string tag);
    drive(1, OP_SW, 1'b1);
    vcheck({tag, "_f"}, 32'(st[1]), 32'd0);
    cyc();
    vcheck({tag, "_d"}, 32'(st[1]), 32'd1);
    cyc();
    vcheck({tag, "_a"}, 32'(st[1]), 32'd2);
    drive(1, OP_SW, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      vcheck({tag, "_wst"}, 32'(st[1]), 32'd5);
      vcheck({tag, "_wem"}, 32'(wem[1]), 32'd1);
      vcheck({tag, "_ret"}, 32'(ret[1]), 32'd0);
    end
    cyc();
    vcheck({tag, "_trap"}, 32'(st[1]), 32'd15);
    vcheck({tag, "_berr"}, 32'(berr[1]), 32'd1);
    vcheck({tag, "_wem0"}, 32'(wem[1]), 32'd0);
    vcheck({tag, "_ill0"}, 32'(ill[1]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0;
      op[i]  = OP_BAD;
      rdy[i] = 1'b0;
    end
    cyc();
    cyc();
    vcheck("rst_st",   32'(st[0]),   32'd0);
    vcheck("rst_mreq", 32'(mreq[0]), 32'd1);
    vcheck("rst_srcb", 32'(sb[0]),   32'd2);
    vcheck("rst_res",  32'(sr[0]),   32'd2);
    vcheck("rst_wir",  32'(wir[0]),  32'd0);
    vcheck("rst_pcu",  32'(pcu[0]),  32'd0);

    // ---- instance 0: defaults ----
    rst[0] = 1'b1;
    drive(0, OP_RTP, 1'b1);
    vcheck("add_f_st",  32'(st[0]),  32'd0);
    vcheck("add_f_wir", 32'(wir[0]), 32'd1);
    vcheck("add_f_pcu", 32'(pcu[0]), 32'd1);
    cyc();
    vcheck("add_d_st",  32'(st[0]),  32'd1);
    vcheck("add_d_sa",  32'(sa[0]),  32'd1);
    vcheck("add_d_sb",  32'(sb[0]),  32'd1);
    vcheck("add_d_wrf", 32'(wrf[0]), 32'd0);
    cyc();
    vcheck("add_e_st",  32'(st[0]),  32'd6);
    vcheck("add_e_sa",  32'(sa[0]),  32'd2);
    vcheck("add_e_aop", 32'(aop[0]), 32'd2);
    vcheck("add_e_wrf", 32'(wrf[0]), 32'd0);
    cyc();
    vcheck("add_w_st",  32'(st[0]),  32'd7);
    vcheck("add_w_wrf", 32'(wrf[0]), 32'd1);
    vcheck("add_w_ret", 32'(ret[0]), 32'd1);
    vcheck("add_w_res", 32'(sr[0]),  32'd0);
    cyc();
    vcheck("add_n_st",  32'(st[0]),  32'd0);
    vcheck("add_n_ret", 32'(ret[0]), 32'd0);

    // LW with three not-ready cycles in S_MEM_RD
    drive(0, OP_LW, 1'b1);
    cyc();
    cyc();
    vcheck("lw_a_st", 32'(st[0]), 32'd2);
    vcheck("lw_a_sb", 32'(sb[0]), 32'd1);
    drive(0, OP_LW, 1'b0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) drive(0, OP_LW, 1'b1);
      vcheck("lw_m_st",   32'(st[0]),   32'd3);
      vcheck("lw_m_sma",  32'(sma[0]),  32'd1);
      vcheck("lw_m_mreq", 32'(mreq[0]), 32'd1);
      vcheck("lw_m_wrf",  32'(wrf[0]),  32'd0);
      if (k < 3) cyc();
    end
    cyc();
    vcheck("lw_w_st",  32'(st[0]),  32'd4);
    vcheck("lw_w_res", 32'(sr[0]),  32'd1);
    vcheck("lw_w_wrf", 32'(wrf[0]), 32'd1);
    vcheck("lw_w_ret", 32'(ret[0]), 32'd1);
    cyc();
    vcheck("lw_n_st", 32'(st[0]), 32'd0);

    // BRANCH
    drive(0, OP_BR, 1'b1);
    cyc();
    cyc();
    vcheck("br_st",  32'(st[0]),  32'd8);
    vcheck("br_br",  32'(br[0]),  32'd1);
    vcheck("br_aop", 32'(aop[0]), 32'd1);
    vcheck("br_ret", 32'(ret[0]), 32'd1);
    cyc();
    vcheck("br_n_st", 32'(st[0]), 32'd0);

    // AUIPC goes straight from decode to writeback
    drive(0, OP_AUIPC, 1'b1);
    cyc();
    cyc();
    vcheck("auipc_st",  32'(st[0]),  32'd7);
    vcheck("auipc_wrf", 32'(wrf[0]), 32'd1);
    cyc();
    vcheck("auipc_n_st", 32'(st[0]), 32'd0);

    // JALR: 0,1,12,10,7,0
    drive(0, OP_JALR, 1'b1);
    cyc();
    vcheck("jalr_d_st", 32'(st[0]), 32'd1);
    cyc();
    vcheck("jalr_a_st",  32'(st[0]),  32'd12);
    vcheck("jalr_a_jcl", 32'(jcl[0]), 32'd0);
    vcheck("jalr_a_pcu", 32'(pcu[0]), 32'd0);
    vcheck("jalr_a_sa",  32'(sa[0]),  32'd2);
    cyc();
    vcheck("jalr_j_st",  32'(st[0]),  32'd10);
    vcheck("jalr_j_jcl", 32'(jcl[0]), 32'd1);
    vcheck("jalr_j_pcu", 32'(pcu[0]), 32'd1);
    vcheck("jalr_j_sb",  32'(sb[0]),  32'd2);
    cyc();
    vcheck("jalr_w_st",  32'(st[0]),  32'd7);
    vcheck("jalr_w_jcl", 32'(jcl[0]), 32'd0);
    vcheck("jalr_w_pcu", 32'(pcu[0]), 32'd0);
    cyc();
    vcheck("jalr_n_st", 32'(st[0]), 32'd0);

    // Illegal opcode traps, then async reset releases it
    drive(0, OP_BAD, 1'b1);
    cyc();
    vcheck("ill_d_ret", 32'(ret[0]), 32'd0);
    cyc();
    vcheck("ill_t_st",   32'(st[0]),   32'd15);
    vcheck("ill_t_ill",  32'(ill[0]),  32'd1);
    vcheck("ill_t_berr", 32'(berr[0]), 32'd0);
    vcheck("ill_t_mreq", 32'(mreq[0]), 32'd0);
    cyc();
    vcheck("ill_hold", 32'(st[0]), 32'd15);
    rst[0] = 1'b0;
    #1;
    vcheck("ill_rst_st",  32'(st[0]),  32'd0);
    vcheck("ill_rst_ill", 32'(ill[0]), 32'd0);

    // ---- instance 1: timeout 5, no JALR ----
    rst[1] = 1'b1;
    drive(1, OP_JALR, 1'b1);
    cyc();
    cyc();
    vcheck("nojalr_st",  32'(st[1]),  32'd15);
    vcheck("nojalr_ill", 32'(ill[1]), 32'd1);
    rst[1] = 1'b0;
    #1;
    vcheck("nojalr_rst", 32'(st[1]), 32'd0);
    cyc();
    rst[1] = 1'b1;
    sw_timeout("sw1");
    cyc();
    vcheck("sw1_hold", 32'(st[1]), 32'd15);
    rst[1] = 1'b0;
    #1;
    vcheck("sw1_rst_st",   32'(st[1]),   32'd0);
    vcheck("sw1_rst_berr", 32'(berr[1]), 32'd0);
    cyc();

    // Reset in the middle of a stalled store
    rst[1] = 1'b1;
    drive(1, OP_SW, 1'b1);
    cyc();
    cyc();
    drive(1, OP_SW, 1'b0);
    cyc();
    cyc();
    cyc();
    vcheck("midrst_pre_st",  32'(st[1]),  32'd5);
    vcheck("midrst_pre_wem", 32'(wem[1]), 32'd1);
    rst[1] = 1'b0;
    #1;
    vcheck("midrst_st",  32'(st[1]),  32'd0);
    vcheck("midrst_wem", 32'(wem[1]), 32'd0);
    cyc();
    rst[1] = 1'b1;
    sw_timeout("sw2");

    // ---- instance 2: illegal returns to fetch, no AUIPC ----
    rst[2] = 1'b1;
    drive(2, OP_BAD, 1'b1);
    cyc();
    vcheck("notrap_d_st",  32'(st[2]),  32'd1);
    vcheck("notrap_d_ret", 32'(ret[2]), 32'd0);
    cyc();
    vcheck("notrap_st",  32'(st[2]),  32'd0);
    vcheck("notrap_ret", 32'(ret[2]), 32'd0);
    vcheck("notrap_ill", 32'(ill[2]), 32'd0);
    drive(2, OP_AUIPC, 1'b1);
    cyc();
    cyc();
    vcheck("noauipc_st",  32'(st[2]),  32'd0);
    vcheck("noauipc_ret", 32'(ret[2]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
